mod_memaccess: RTL and testbench
================================

# mod_memaccess

Data-memory access controller for the memory stage. It accepts one load or store request at a time from the memory-stage control and runs the matching bus transaction on the SBU line-oriented bus. For a load it returns the selected 64-bit word and pulses `load_done`. For a store it performs a line read-modify-write and drives `store_opn` low when the write-back finishes. It sits directly downstream of the memory stage and generates that stage's `memstage_active`, `store_memstage_active`, `load_done` and `store_opn` inputs.

## Interface
- `ADDR_W`, 64: address width, bit 0 = MSB.
- `DATA_W`, 64: bus beat and word width.
- `LINE_BEATS`, 8: beats per cache line (64-byte line).
- `clk` input 1: clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `ld_req` input 1: load request (memstage `data_reqFlag`), level.
- `st_req` input 1: store request (memstage `store_reqFlag`), level.
- `req_addr` input [0:ADDR_W-1]: byte address, sampled on accept.
- `st_data` input [0:DATA_W-1]: store word, sampled on accept.
- `memstage_active` output 1: load accepted and not yet done.
- `store_memstage_active` output 1: store accepted and not yet done.
- `load_done` output 1: one-cycle pulse, `load_buffer` valid.
- `load_buffer` output [0:DATA_W-1]: last loaded word, held.
- `store_opn` output 1: store in progress.
- `bus_reqcyc` output 1: request/write-data valid.
- `bus_reqack` input 1: bus accepted current request cycle.
- `bus_req` output [0:DATA_W-1]: line address, then write beats.
- `bus_reqtag` output [0:1]: 2'b01 read, 2'b10 write, 0 idle.
- `bus_respcyc` input 1: read beat valid.
- `bus_respack` output 1: equals `bus_respcyc` in RD_DATA, else 0.
- `bus_resp` input [0:DATA_W-1]: read beat.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE.
- IDLE: `ld_req` accepted, or `st_req` if `ld_req`=0 (load wins when both are high). Latch `req_addr` and `st_data`, set the op flag, go to RD_REQ.
- Line address = `req_addr` with the low 6 bits zeroed. Word index = `req_addr[ADDR_W-6:ADDR_W-4]`. The low 3 bits are ignored because accesses are 8-byte aligned.
- RD_REQ: `bus_reqcyc`=1, `bus_req`=line address, tag 01. Hold until `bus_reqack`, then go to RD_DATA with beat counter 0.
- RD_DATA: each beat with `bus_respcyc` is written into `line[cnt]` and `cnt` increments.
  - On beat LINE_BEATS-1 for a load: `load_buffer` ← that line word, then go to DONE.
  - On beat LINE_BEATS-1 for a store: `line[idx]` ← `st_data`, then go to WR_REQ.
- WR_REQ: `bus_reqcyc`=1, `bus_req`=line address, tag 10. Hold until `bus_reqack`, then go to WR_DATA with `cnt`=0.
- WR_DATA: `bus_reqcyc`=1, `bus_req`=`line[cnt]`. Each `bus_reqack` advances `cnt`; the ack on beat LINE_BEATS-1 moves to DONE.
- DONE (one cycle): a load pulses `load_done`; a store drops `store_opn`. Both then return to IDLE. A new request can be accepted in the IDLE cycle that follows.
- `memstage_active` = load op flag and not IDLE. `store_memstage_active` and `store_opn` = store op flag and not IDLE; both fall in DONE.
- Beat counter is $clog2(LINE_BEATS) bits wide and wraps to 0 only on a state change.

## Timing
- Reset (async assert, sync release): state IDLE; every output 0 including `load_buffer`; line store is don't-care. Reset mid-transaction aborts it, with no `load_done` and no pending bus cycle.
- Accept at cycle T. `bus_reqcyc` rises at T+1.
- Load with zero-wait bus: ack at T+1, beats T+2..T+9, DONE/`load_done` at T+10.
- Store with zero-wait bus: read beats end T+9, WR_REQ T+10, write beats T+11..T+18, DONE T+19.
- `bus_respcyc` outside RD_DATA is ignored, with `bus_respack`=0.
- Requests arriving while not IDLE are ignored; the level is re-sampled in IDLE.

## Configuration
- `MEMACC_LINE_BUFFER_EN` defined:
  - Retain the last fetched line plus its line address and a valid bit.
  - A load whose line address matches a valid entry skips the bus: `load_done` fires at T+1 with the word.
  - A store always does its full bus write-back and updates the buffer.
  - Reset clears the valid bit.
- Not defined: every access uses the bus and hit logic is absent.

## Test plan
- Load at 0x1028, zero-wait bus returning beat k = 0x100+k -> one read to 0x1000, `load_done` at T+10, `load_buffer`=0x105.
- Store 0xDEADBEEF at 0x2010, read beats k = k -> write to 0x2000 with beats 0,1,0xDEADBEEF,3..7, `store_opn` falls at T+19.
- `ld_req` and `st_req` high together -> load served first; store accepted the cycle after DONE.
- `bus_reqack` held low 5 cycles and beats gapped by 2 cycles -> request and address stable, correct word, no `load_done` early.
- `reset_n` low during RD_DATA beat 3 -> all outputs 0 immediately; next load completes normally.
- With `MEMACC_LINE_BUFFER_EN`: second load to 0x1030 after 0x1028 -> no `bus_reqcyc`, `load_done` at T+1, value 0x106.

Source files
------------

// File: rtl/mod_memaccess_if.sv
// SBU line-oriented bus between the memory-access controller (master) and
// the data memory / bus fabric (slave).
interface mod_memaccess_if #(
    parameter int DATA_W = 64
);
    logic              bus_reqcyc;
    logic              bus_reqack;
    logic [0:DATA_W-1] bus_req;
    logic [0:1]        bus_reqtag;
    logic              bus_respcyc;
    logic              bus_respack;
    logic [0:DATA_W-1] bus_resp;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp
    );
endinterface

// File: rtl/mod_memaccess.sv
// Data-memory access controller for the memory stage: runs one load
// (line read, word select) or store (line read-modify-write) at a time
// on the SBU bus. Bit 0 of every address/data vector is the MSB.
// Optional feature macro: MEMACC_LINE_BUFFER_EN keeps the last line so
// loads that hit it complete without a bus transaction.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for ld_req / st_req (load has priority)
// S_RD_REQ  | line read request on the bus, wait for ack
// S_RD_DATA | collecting LINE_BEATS read beats into line_q
// S_WR_REQ  | line write request on the bus, wait for ack
// S_WR_DATA | sending LINE_BEATS write beats from line_q
// S_DONE    | one cycle: load_done pulse / store_opn drops
module mod_memaccess #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [0:ADDR_W-1] req_addr,
    input  logic [0:DATA_W-1] st_data,
    output logic              memstage_active,
    output logic              store_memstage_active,
    output logic              load_done,
    output logic [0:DATA_W-1] load_buffer,
    output logic              store_opn,
    mod_memaccess_if.master   bus
);
    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam int OFF_W = CNT_W + 3;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    typedef logic [0:ADDR_W-1] addr_t;
    typedef logic [0:DATA_W-1] word_t;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_DATA, S_WR_REQ, S_WR_DATA, S_DONE
    } state_t;

    function automatic addr_t line_of(input addr_t a);
        line_of = {a[0:ADDR_W-OFF_W-1], {OFF_W{1'b0}}};
    endfunction

    function automatic logic [CNT_W-1:0] idx_of(input addr_t a);
        idx_of = a[ADDR_W-OFF_W:ADDR_W-4];
    endfunction

    // Byte-within-word bits: accesses are 8-byte aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[ADDR_W-3:ADDR_W-1];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    addr_t            acc_line_q, acc_line_d;
    word_t            wdata_q, wdata_d;
    logic             is_load_q, is_load_d;
    word_t            line_q [LINE_BEATS];
    word_t            line_d [LINE_BEATS];
    word_t            load_buffer_q, load_buffer_d;
    logic             load_done_q, load_done_d;
    logic             ld_active_q, ld_active_d;
    logic             st_active_q, st_active_d;
    logic             reqcyc_q, reqcyc_d;
    word_t            req_q, req_d;
    logic [0:1]       reqtag_q, reqtag_d;
`ifdef MEMACC_LINE_BUFFER_EN
    logic             buf_valid_q, buf_valid_d;
    addr_t            buf_line_q, buf_line_d;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        acc_line_d    = acc_line_q;
        wdata_d       = wdata_q;
        is_load_d     = is_load_q;
        line_d        = line_q;
        load_buffer_d = load_buffer_q;
`ifdef MEMACC_LINE_BUFFER_EN
        buf_valid_d   = buf_valid_q;
        buf_line_d    = buf_line_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld_req || st_req) begin
                    acc_line_d = line_of(req_addr);
                    idx_d      = idx_of(req_addr);
                    wdata_d    = st_data;
                    is_load_d  = ld_req;
                    cnt_d      = '0;
                    state_d    = S_RD_REQ;
`ifdef MEMACC_LINE_BUFFER_EN
                    if (ld_req && buf_valid_q && (line_of(req_addr) == buf_line_q)) begin
                        load_buffer_d = line_q[idx_of(req_addr)];
                        state_d       = S_DONE;
                    end
`endif
                end
            end
            S_RD_REQ: begin
                if (bus.bus_reqack) begin
                    cnt_d   = '0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (bus.bus_respcyc) begin
                    line_d[cnt_q] = bus.bus_resp;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d = '0;
                        if (is_load_q) begin
                            load_buffer_d = line_d[idx_q];
                            state_d       = S_DONE;
`ifdef MEMACC_LINE_BUFFER_EN
                            buf_valid_d   = 1'b1;
                            buf_line_d    = acc_line_q;
`endif
                        end else begin
                            line_d[idx_q] = wdata_q;
                            state_d       = S_WR_REQ;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WR_REQ: begin
                if (bus.bus_reqack) begin
                    cnt_d   = '0;
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (bus.bus_reqack) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d       = '0;
                        state_d     = S_DONE;
`ifdef MEMACC_LINE_BUFFER_EN
                        buf_valid_d = 1'b1;
                        buf_line_d  = acc_line_q;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        load_done_d = (state_d == S_DONE) && is_load_d;
        ld_active_d = is_load_d && (state_d != S_IDLE);
        st_active_d = !is_load_d && (state_d != S_IDLE) && (state_d != S_DONE);
        reqcyc_d    = (state_d == S_RD_REQ) || (state_d == S_WR_REQ) || (state_d == S_WR_DATA);
        case (state_d)
            S_RD_REQ:  begin reqtag_d = 2'b01; req_d = acc_line_d;    end
            S_WR_REQ:  begin reqtag_d = 2'b10; req_d = acc_line_d;    end
            S_WR_DATA: begin reqtag_d = 2'b10; req_d = line_d[cnt_d]; end
            default:   begin reqtag_d = 2'b00; req_d = '0;            end
        endcase
    end

    // All controller state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            acc_line_q    <= '0;
            wdata_q       <= '0;
            is_load_q     <= 1'b0;
            for (int i = 0; i < LINE_BEATS; i++) line_q[i] <= '0;
            load_buffer_q <= '0;
            load_done_q   <= 1'b0;
            ld_active_q   <= 1'b0;
            st_active_q   <= 1'b0;
            reqcyc_q      <= 1'b0;
            req_q         <= '0;
            reqtag_q      <= 2'b00;
`ifdef MEMACC_LINE_BUFFER_EN
            buf_valid_q   <= 1'b0;
            buf_line_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            acc_line_q    <= acc_line_d;
            wdata_q       <= wdata_d;
            is_load_q     <= is_load_d;
            line_q        <= line_d;
            load_buffer_q <= load_buffer_d;
            load_done_q   <= load_done_d;
            ld_active_q   <= ld_active_d;
            st_active_q   <= st_active_d;
            reqcyc_q      <= reqcyc_d;
            req_q         <= req_d;
            reqtag_q      <= reqtag_d;
`ifdef MEMACC_LINE_BUFFER_EN
            buf_valid_q   <= buf_valid_d;
            buf_line_q    <= buf_line_d;
`endif
        end
    end

    assign memstage_active       = ld_active_q;
    assign store_memstage_active = st_active_q;
    assign store_opn             = st_active_q;
    assign load_done             = load_done_q;
    assign load_buffer           = load_buffer_q;
    assign bus.bus_reqcyc        = reqcyc_q;
    assign bus.bus_req           = req_q;
    assign bus.bus_reqtag        = reqtag_q;
    // Read beats are only taken while collecting a line.
    assign bus.bus_respack       = bus.bus_respcyc && (state_q == S_RD_DATA);
endmodule

// File: tb/tb_mod_memaccess.sv
// Bench for mod_memaccess: bus slave with programmable ack/beat delays
// backed by a word memory, and a word-level reference memory predicting
// load results, write-back lines and zero-wait latencies.
module tb_mod_memaccess;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_req, st_req;
    logic [0:63] req_addr, st_data;
    logic        memstage_active, store_memstage_active, load_done, store_opn;
    logic [0:63] load_buffer;

    always #5 clk = ~clk;

    mod_memaccess_if #(.DATA_W(64)) bus_if ();

    mod_memaccess #(.ADDR_W(64), .DATA_W(64), .LINE_BEATS(8)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .ld_req                (ld_req),
        .st_req                (st_req),
        .req_addr              (req_addr),
        .st_data               (st_data),
        .memstage_active       (memstage_active),
        .store_memstage_active (store_memstage_active),
        .load_done             (load_done),
        .load_buffer           (load_buffer),
        .store_opn             (store_opn),
        .bus                   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference memory (what software would see) and bus-side memory.
    bit [63:0] ref_mem [bit [63:0]];
    bit [63:0] bus_mem [bit [63:0]];

    function automatic bit [63:0] dflt(input bit [63:0] w);
        return (w * 64'h9E3779B97F4A7C15) ^ 64'h5A5A_0000_5A5A;
    endfunction
    function automatic bit [63:0] ref_get(input bit [63:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction
    function automatic bit [63:0] bus_get(input bit [63:0] w);
        return bus_mem.exists(w) ? bus_mem[w] : dflt(w);
    endfunction
    task automatic preload(input bit [63:0] line_addr, input bit [63:0] base);
        for (int k = 0; k < 8; k++) begin
            ref_mem[(line_addr >> 3) + 64'(k)] = base + 64'(k);
            bus_mem[(line_addr >> 3) + 64'(k)] = base + 64'(k);
        end
    endtask

    // Bus slave
    int          ack_delay = 0, beat_gap = 0;
    bit          stray_en  = 0;
    int          sl_phase = 0, sl_wait = 0, sl_gap = 0, sl_beat = 0;
    bit   [63:0] sl_line;
    logic [0:63] sl_req0;
    logic [0:1]  sl_tag0;
    int          rd_count = 0, wr_count = 0;
    bit   [63:0] last_rd = 0, last_wr = 0;

    initial begin
        bus_if.bus_reqack  = 1'b0;
        bus_if.bus_respcyc = 1'b0;
        bus_if.bus_resp    = '0;
    end

    always @(negedge clk) begin
        bus_if.bus_reqack  = 1'b0;
        bus_if.bus_respcyc = 1'b0;
        if (!reset_n) begin
            sl_phase = 0; sl_wait = 0; sl_gap = 0; sl_beat = 0;
        end else begin
            case (sl_phase)
                0: begin
                    if (bus_if.bus_reqcyc) begin
                        if (sl_wait == 0) begin
                            sl_req0 = bus_if.bus_req;
                            sl_tag0 = bus_if.bus_reqtag;
                        end else begin
                            chk("req_stable", bus_if.bus_req, sl_req0);
                            chk("tag_stable", 64'(bus_if.bus_reqtag), 64'(sl_tag0));
                        end
                        if (sl_wait < ack_delay) sl_wait++;
                        else begin
                            bus_if.bus_reqack = 1'b1;
                            sl_wait = 0; sl_beat = 0; sl_gap = 0;
                            sl_line = bus_if.bus_req;
                            if (bus_if.bus_reqtag == 2'b01) begin
                                sl_phase = 1; rd_count++; last_rd = sl_line;
                            end else if (bus_if.bus_reqtag == 2'b10) begin
                                sl_phase = 2; wr_count++; last_wr = sl_line;
                            end else begin
                                chk("req_tag_valid", 64'(bus_if.bus_reqtag), 64'h1);
                            end
                        end
                    end
                    if (stray_en && !bus_if.bus_reqack && ($urandom_range(1, 0) == 1)) begin
                        bus_if.bus_respcyc = 1'b1;
                        bus_if.bus_resp    = {$urandom, $urandom};
                        #1;
                        chk("respack_ignored", 64'(bus_if.bus_respack), 64'h0);
                    end
                end
                1: begin
                    if (sl_gap < beat_gap) sl_gap++;
                    else begin
                        sl_gap = 0;
                        bus_if.bus_respcyc = 1'b1;
                        bus_if.bus_resp    = bus_get((sl_line >> 3) + 64'(sl_beat));
                        sl_beat++;
                        if (sl_beat == 8) sl_phase = 0;
                    end
                    #1;
                    chk("respack_rd", 64'(bus_if.bus_respack), 64'(bus_if.bus_respcyc));
                end
                default: begin
                    chk("wr_reqcyc", 64'(bus_if.bus_reqcyc), 64'h1);
                    if (sl_gap < beat_gap) sl_gap++;
                    else begin
                        sl_gap = 0;
                        bus_if.bus_reqack = 1'b1;
                        bus_mem[(sl_line >> 3) + 64'(sl_beat)] = bus_if.bus_req;
                        sl_beat++;
                        if (sl_beat == 8) sl_phase = 0;
                    end
                end
            endcase
        end
    end

    // Latency in cycles from the accept edge, at the standard bus timing.
    function automatic int exp_latency(input bit is_ld);
        int rd;
        rd = 1 + (ack_delay + 1) + 8 * (beat_gap + 1);
        return is_ld ? rd : rd + (ack_delay + 1) + 8 * (beat_gap + 1);
    endfunction

    task automatic wait_done(input bit is_ld, input string tag, output int n);
        bit done;
        n = 1;
        done = is_ld ? load_done : !store_opn;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
            done = is_ld ? load_done : !store_opn;
        end
        if (!done) chk({tag, "_timeout"}, 64'(done), 64'h1);
    endtask

    task automatic finish_check(input bit is_ld, input bit [63:0] a, input bit [63:0] d,
                                input int n, input int exp_lat, input string tag);
        bit [63:0] w, lw;
        w  = a >> 3;
        lw = (a >> 6) << 3;
        if (exp_lat >= 0) chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        if (is_ld) begin
            chk({tag, "_data"}, load_buffer, ref_get(w));
            @(negedge clk);
            chk({tag, "_pulse_end"}, 64'(load_done), 64'h0);
            chk({tag, "_active_end"}, 64'(memstage_active), 64'h0);
        end else begin
            chk({tag, "_st_active_end"}, 64'(store_memstage_active), 64'h0);
            ref_mem[w] = d;
            for (int k = 0; k < 8; k++)
                chk($sformatf("%s_wb%0d", tag, k), bus_get(lw + 64'(k)), ref_get(lw + 64'(k)));
            @(negedge clk);
        end
    endtask

    task automatic run_op(input bit is_ld, input bit [63:0] a, input bit [63:0] d,
                          input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        ld_req = is_ld; st_req = !is_ld; req_addr = a; st_data = d;
        @(negedge clk);
        ld_req = 1'b0; st_req = 1'b0;
        if (is_ld) chk({tag, "_active"}, 64'(memstage_active), 64'h1);
        else       chk({tag, "_opn"}, 64'(store_opn), 64'h1);
        wait_done(is_ld, tag, n);
        finish_check(is_ld, a, d, n, exp_lat, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n, rd0, wr0;
        bit [63:0] a, d;
        bit is_ld;
        reset_n = 1'b0; ld_req = 1'b0; st_req = 1'b0; req_addr = '0; st_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ld_active", 64'(memstage_active), 64'h0);
        chk("rst_st_active", 64'(store_memstage_active), 64'h0);
        chk("rst_load_done", 64'(load_done), 64'h0);
        chk("rst_store_opn", 64'(store_opn), 64'h0);
        chk("rst_load_buffer", load_buffer, 64'h0);
        chk("rst_reqcyc", 64'(bus_if.bus_reqcyc), 64'h0);
        chk("rst_reqtag", 64'(bus_if.bus_reqtag), 64'h0);
        reset_n = 1'b1;

        // Zero-wait load
        preload(64'h1000, 64'h100);
        run_op(1, 64'h1028, 0, 10, "ld1");
        chk("ld1_rd_count", 64'(rd_count), 64'h1);
        chk("ld1_wr_count", 64'(wr_count), 64'h0);
        chk("ld1_rd_addr", last_rd, 64'h1000);
        chk("ld1_value", load_buffer, 64'h105);
`ifdef MEMACC_LINE_BUFFER_EN
        run_op(1, 64'h1030, 0, 1, "hit");
        chk("hit_no_bus", 64'(rd_count), 64'h1);
        @(negedge clk);
        chk("hit_value", load_buffer, 64'h106);
`endif

        // Zero-wait store RMW
        preload(64'h2000, 64'h0);
        rd0 = rd_count; wr0 = wr_count;
        run_op(0, 64'h2010, 64'hDEADBEEF, 19, "st1");
        chk("st1_rd_count", 64'(rd_count), 64'(rd0 + 1));
        chk("st1_wr_count", 64'(wr_count), 64'(wr0 + 1));
        chk("st1_wr_addr", last_wr, 64'h2000);
        chk("st1_word2", bus_get(64'h2010 >> 3), 64'hDEADBEEF);
        chk("st1_word3", bus_get((64'h2000 >> 3) + 3), 64'h3);

        // Load and store requested together: load first, store next IDLE cycle
        a = 64'h5018; d = {$urandom, $urandom};
        @(negedge clk);
        ld_req = 1'b1; st_req = 1'b1; req_addr = a; st_data = d;
        @(negedge clk);
        ld_req = 1'b0;
        chk("both_ld_first", 64'(memstage_active), 64'h1);
        chk("both_st_waits", 64'(store_opn), 64'h0);
        wait_done(1, "both_ld", n);
        chk("both_ld_lat", 64'(n), 64'd10);
        chk("both_ld_data", load_buffer, ref_get(a >> 3));
        @(negedge clk);
        chk("both_idle_gap", 64'(store_memstage_active), 64'h0);
        @(negedge clk);
        chk("both_st_accept", 64'(store_memstage_active), 64'h1);
        st_req = 1'b0;
        wait_done(0, "both_st", n);
        finish_check(0, a, d, n, 19, "both_st");

        // Stalled request and gapped beats
        ack_delay = 5; beat_gap = 2;
        run_op(1, 64'h6038, 0, 31, "stall");
        ack_delay = 0; beat_gap = 0;

        // Reset during read beat 3
        @(negedge clk);
        ld_req = 1'b1; req_addr = 64'h3008;
        @(negedge clk);
        ld_req = 1'b0;
        n = 0;
        forever begin
            @(negedge clk); #2;
            n++;
            if (sl_beat >= 4 || n > 50) break;
        end
        reset_n = 1'b0;
        #1;
        chk("arst_ld_active", 64'(memstage_active), 64'h0);
        chk("arst_load_done", 64'(load_done), 64'h0);
        chk("arst_load_buffer", load_buffer, 64'h0);
        chk("arst_store_opn", 64'(store_opn), 64'h0);
        chk("arst_reqcyc", 64'(bus_if.bus_reqcyc), 64'h0);
        chk("arst_reqtag", 64'(bus_if.bus_reqtag), 64'h0);
        chk("arst_respack", 64'(bus_if.bus_respack), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_done", 64'(load_done), 64'h0);
        end
        run_op(1, 64'h3010, 0, 10, "after_rst");

        // Randomized traffic over a few lines with stray response beats
        stray_en = 1;
        for (int i = 0; i < 40; i++) begin
            a = 64'h4000 + 64'($urandom_range(3, 0) << 6) + 64'($urandom_range(7, 0) << 3)
                + 64'($urandom_range(7, 0));
            d = {$urandom, $urandom};
            is_ld = ($urandom_range(1, 0) == 1);
            ack_delay = $urandom_range(2, 0);
            beat_gap  = $urandom_range(1, 0);
`ifdef MEMACC_LINE_BUFFER_EN
            run_op(is_ld, a, d, is_ld ? -1 : exp_latency(0), $sformatf("rnd%0d", i));
`else
            run_op(is_ld, a, d, exp_latency(is_ld), $sformatf("rnd%0d", i));
`endif
        end
        stray_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
